// File: rtl/clock_pkg.sv
// Shared types and constants for the MM:SS clock mode controller.
package clock_pkg;

    // Controller operating mode
    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // BCD rollover points: seconds wrap from 59 to 00 and carry into minutes
    localparam logic [3:0] SEC_TEN_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-flop synchronizer, stability filter and a
// registered one-cycle pulse on each accepted rising edge.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Bring the asynchronous input into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples;
    // any sample that matches the current level restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync1 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // One-cycle press pulse on the rising edge of the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN/PAUSED/ADJUST mode controller for the MM:SS counter. Generates the
// single-cycle increment and clear strobes plus the adjust blink phase.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int FAST_DIV  = 25_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_adj,
    input  logic       btn_clr,
    input  logic       sel,
    input  logic [3:0] sec_ten,
    input  logic [3:0] sec_one,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       clr,
    output logic       paused,
    output logic       adjusting,
    output logic       blink
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);

    logic pause_press, pause_level;
    logic adj_press, adj_level;
    logic clr_press, clr_level;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .reset(reset), .raw(btn_pause), .level(pause_level), .press(pause_press)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
        .clk(clk), .reset(reset), .raw(btn_adj), .level(adj_level), .press(adj_press)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .reset(reset), .raw(btn_clr), .level(clr_level), .press(clr_press)
    );

    // Only the adjust level and the pause/clear pulses drive the FSM
    logic unused_db;
    assign unused_db = &{1'b0, pause_level, adj_press, clr_level};

    state_t          state;
    state_t          saved_mode;
    logic [TW-1:0]   tick_cnt;
    logic [FW-1:0]   fast_cnt;

    logic run_wrap;
    logic fast_wrap;
    logic at_59;
    assign run_wrap  = (tick_cnt == TICK_LAST);
    assign fast_wrap = (fast_cnt == FAST_LAST);
    assign at_59     = (sec_ten == SEC_TEN_MAX) && (sec_one == DIGIT_MAX);

    // Mode FSM, counters and registered strobes. Priority in RUN/PAUSED is
    // clear, then adjust entry, then pause toggle, then the run tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PAUSED;
            saved_mode <= PAUSED;
            tick_cnt   <= '0;
            fast_cnt   <= '0;
            blink      <= 1'b0;
            sec_inc    <= 1'b0;
            min_inc    <= 1'b0;
            clr        <= 1'b0;
        end else begin
            sec_inc <= 1'b0;
            min_inc <= 1'b0;
            clr     <= 1'b0;
            case (state)
                PAUSED, RUN: begin
                    if (clr_press) begin
                        clr      <= 1'b1;
                        tick_cnt <= '0;
                        state    <= PAUSED;
                    end else if (adj_level) begin
                        saved_mode <= state;
                        state      <= ADJUST;
                        fast_cnt   <= '0;
                        blink      <= 1'b0;
                    end else if (pause_press) begin
                        state <= (state == RUN) ? PAUSED : RUN;
                    end else if (state == RUN) begin
                        if (run_wrap) begin
                            tick_cnt <= '0;
                            sec_inc  <= 1'b1;
                            min_inc  <= at_59;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ADJUST: begin
                    if (!adj_level) begin
                        // Leaving adjust: a coincident clear still wins and parks us
                        state    <= clr_press ? PAUSED : saved_mode;
                        tick_cnt <= '0;
                        blink    <= 1'b0;
                        clr      <= clr_press;
                    end else begin
                        fast_cnt <= fast_wrap ? '0 : fast_cnt + 1'b1;
                        if (fast_wrap) begin
                            blink <= ~blink;
                            // sel is sampled only here, so a change lands on the next wrap
                            if (!clr_press) begin
                                sec_inc <= sel;
                                min_inc <= ~sel;
                            end
                        end
                        if (clr_press) begin
                            clr        <= 1'b1;
                            saved_mode <= PAUSED;
                            tick_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= PAUSED;
                end
            endcase
        end
    end

    assign paused    = (state == PAUSED);
    assign adjusting = (state == ADJUST);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomized bench for clock_mode_ctrl against a behavioural model:
// debounce as a sliding window over input history, timing as modular counts.
module tb_clock_mode_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int FAST_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int HL        = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_pause, btn_adj, btn_clr, sel;
    logic [3:0] sec_ten, sec_one;
    logic       sec_inc, min_inc, clr, paused, adjusting, blink;

    clock_mode_ctrl #(.TICK_DIV(TICK_DIV), .FAST_DIV(FAST_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_adj(btn_adj),
        .btn_clr(btn_clr), .sel(sel), .sec_ten(sec_ten), .sec_one(sec_one),
        .sec_inc(sec_inc), .min_inc(min_inc), .clr(clr), .paused(paused),
        .adjusting(adjusting), .blink(blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model: mode 0=paused 1=run 2=adjust; buttons 0=pause 1=adj 2=clr
    int m_mode, m_saved, m_tick, m_fast, m_blink, m_sinc, m_minc, m_clr;
    int hist[3][HL];
    int lvl[3], lvld[3], prs[3];

    task automatic model_reset();
        m_mode = 0; m_saved = 0; m_tick = 0; m_fast = 0; m_blink = 0;
        m_sinc = 0; m_minc = 0; m_clr = 0;
        for (int b = 0; b < 3; b++) begin
            lvl[b] = 0; lvld[b] = 0; prs[b] = 0;
            for (int k = 0; k < HL; k++) hist[b][k] = 0;
        end
    endtask

    task automatic model_edge(input int raw0, input int raw1, input int raw2,
                              input int s, input int st, input int so);
        int pp, al, cp, flip;
        int raw[3];
        raw[0] = raw0; raw[1] = raw1; raw[2] = raw2;
        pp = prs[0]; al = lvl[1]; cp = prs[2];
        m_sinc = 0; m_minc = 0; m_clr = 0;
        if (m_mode != 2) begin
            if (cp) begin
                m_clr = 1; m_tick = 0; m_mode = 0;
            end else if (al) begin
                m_saved = m_mode; m_mode = 2; m_fast = 0; m_blink = 0;
            end else if (pp) begin
                m_mode = 1 - m_mode;
            end else if (m_mode == 1) begin
                m_tick = (m_tick + 1) % TICK_DIV;
                if (m_tick == 0) begin
                    m_sinc = 1;
                    m_minc = (st == 5 && so == 9) ? 1 : 0;
                end
            end
        end else begin
            if (!al) begin
                m_mode = cp ? 0 : m_saved; m_tick = 0; m_blink = 0; m_clr = cp;
            end else begin
                m_fast = (m_fast + 1) % FAST_DIV;
                if (m_fast == 0) begin
                    m_blink = 1 - m_blink;
                    if (!cp) begin
                        if (s) m_sinc = 1; else m_minc = 1;
                    end
                end
                if (cp) begin
                    m_clr = 1; m_saved = 0; m_tick = 0;
                end
            end
        end
        // debounce: the synchronized sample at this edge is the raw value from
        // two edges ago; the level flips once DB_CYCLES such samples all oppose it
        for (int b = 0; b < 3; b++) begin
            flip = 1;
            for (int k = 1; k <= DB_CYCLES; k++)
                if (hist[b][k] == lvl[b]) flip = 0;
            prs[b]  = (lvl[b] && !lvld[b]) ? 1 : 0;
            lvld[b] = lvl[b];
            if (flip) lvl[b] = 1 - lvl[b];
            for (int k = HL - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = raw[b];
        end
    endtask

    task automatic step(input logic rs, input logic bp, input logic ba, input logic bc,
                        input logic s, input logic [3:0] st, input logic [3:0] so);
        reset = rs; btn_pause = bp; btn_adj = ba; btn_clr = bc;
        sel = s; sec_ten = st; sec_one = so;
        @(posedge clk);
        if (rs) model_reset();
        else model_edge(int'(bp), int'(ba), int'(bc), int'(s), int'(st), int'(so));
        #1;
        chk("sec_inc",   32'(sec_inc),   32'(m_sinc));
        chk("min_inc",   32'(min_inc),   32'(m_minc));
        chk("clr",       32'(clr),       32'(m_clr));
        chk("paused",    32'(paused),    32'(m_mode == 0));
        chk("adjusting", 32'(adjusting), 32'(m_mode == 2));
        chk("blink",     32'(blink),     32'(m_blink));
    endtask

    task automatic hold(input int n, input logic bp, input logic ba, input logic bc,
                        input logic s, input logic [3:0] st, input logic [3:0] so);
        for (int i = 0; i < n; i++) step(1'b0, bp, ba, bc, s, st, so);
    endtask

    int dur[3];
    logic val[3];
    logic rsel;

    initial begin
        model_reset();
        // reset state
        step(1'b1, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b1, 0, 0, 0, 0, 4'd0, 4'd0);
        chk("rst_paused", 32'(paused), 32'd1);
        // pause press -> RUN, ticks; include a :59 carry window
        hold(8, 1, 0, 0, 0, 4'd1, 4'd2);
        hold(25, 0, 0, 0, 0, 4'd5, 4'd9);
        chk("run_state", 32'(paused), 32'd0);
        // glitch must be rejected, then a real 5-cycle hold toggles to PAUSED
        hold(2, 1, 0, 0, 0, 4'd0, 4'd0);
        hold(10, 0, 0, 0, 0, 4'd0, 4'd0);
        hold(5, 1, 0, 0, 0, 4'd0, 4'd0);
        hold(10, 0, 0, 0, 0, 4'd0, 4'd0);
        hold(8, 1, 0, 0, 0, 4'd0, 4'd0);
        hold(5, 0, 0, 0, 0, 4'd0, 4'd0);
        // adjust minutes from RUN with pause presses mixed in, then release
        hold(10, 0, 1, 0, 0, 4'd5, 4'd9);
        hold(6, 1, 1, 0, 0, 4'd5, 4'd9);
        hold(14, 0, 1, 0, 0, 4'd5, 4'd9);
        hold(25, 0, 0, 0, 0, 4'd0, 4'd0);
        // simultaneous clear and pause in RUN
        hold(6, 1, 0, 1, 0, 4'd5, 4'd9);
        hold(20, 0, 0, 0, 0, 4'd5, 4'd9);
        // adjust seconds, then reset mid-adjust
        hold(20, 0, 1, 0, 1, 4'd0, 4'd0);
        step(1'b1, 0, 1, 0, 1, 4'd0, 4'd0);
        chk("rst_adj_exit", 32'(adjusting), 32'd0);
        hold(3, 0, 0, 0, 0, 4'd0, 4'd0);

        // randomized phase: each button holds a value for a random duration,
        // mixing sub-threshold glitches with accepted presses
        for (int b = 0; b < 3; b++) begin dur[b] = 0; val[b] = 1'b0; end
        rsel = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    val[b] = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
                    if (b == 1 && val[b]) dur[b] = $urandom_range(1, 40);
                    else if (b == 2 && val[b]) dur[b] = $urandom_range(1, 6);
                    else dur[b] = $urandom_range(1, 12);
                    if (b == 2 && $urandom_range(0, 3) != 0) val[b] = 1'b0;
                end
                dur[b]--;
            end
            if ($urandom_range(0, 15) == 0) rsel = ~rsel;
            step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, val[0], val[1], val[2], rsel,
                 ($urandom_range(0, 1) == 0) ? 4'd5 : 4'($urandom_range(0, 5)),
                 ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom_range(0, 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode controller for the MM:SS clock counter. It debounces the front-panel buttons and runs a RUN/PAUSED/ADJUST state machine. It produces the single-cycle `sec_inc`, `min_inc` and `clr` strobes that drive the counter, including the minute carry at :59 and fast-set stepping while adjusting. It sits between the board I/O and the counter, and its `blink` output feeds the display driver.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per 1 Hz run tick.
- `FAST_DIV`, 25_000_000: clk cycles per adjust-rate tick (4 Hz).
- `DB_CYCLES`, 1_000_000: cycles a synchronized input must be stable to be accepted.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `btn_pause` in 1: raw asynchronous button; toggles run/pause.
- `btn_adj` in 1: raw asynchronous button; held to adjust.
- `btn_clr` in 1: raw asynchronous button; clears time.
- `sel` in 1: static switch; 1 = adjust seconds, 0 = adjust minutes.
- `sec_ten` in 4: current counter tens-of-seconds, BCD.
- `sec_one` in 4: current counter units-of-seconds, BCD.
- `sec_inc` out 1: one-cycle pulse that advances seconds.
- `min_inc` out 1: one-cycle pulse that advances minutes.
- `clr` out 1: one-cycle pulse that zeroes the counter.
- `paused` out 1: high in PAUSED.
- `adjusting` out 1: high in ADJUST.
- `blink` out 1: display blanking phase; 0 outside ADJUST.

## Operation
- Reset: state PAUSED, saved mode PAUSED, all counters 0. Outputs: `sec_inc`=0, `min_inc`=0, `clr`=0, `paused`=1, `adjusting`=0, `blink`=0.
- **Debounce**, per button:
  - Two-flop synchronizer.
  - A counter runs while the synchronized value differs from the debounced level. A match before DB_CYCLES consecutive cycles resets the counter, so glitches are rejected.
  - Rising edge of the debounced level gives a one-cycle registered press pulse.
- **RUN**:
  - Tick counter counts 0..TICK_DIV-1 and wraps.
  - At wrap, `sec_inc` pulses.
  - `min_inc` pulses in the same cycle if `sec_ten`==5 and `sec_one`==9 on that cycle.
- **PAUSED**: tick counter frozen (holds its value); no increments.
- **Transitions**:
  - Pause press: RUN→PAUSED, PAUSED→RUN.
  - Debounced `btn_adj` level high in RUN or PAUSED: save current mode, go to ADJUST.
  - `btn_adj` level low in ADJUST: return to saved mode with tick counter cleared to 0.
- **ADJUST**:
  - Fast counter counts 0..FAST_DIV-1.
  - At wrap, pulse `sec_inc` if `sel`=1, else `min_inc`. Never both, and no carry in ADJUST.
  - `blink` toggles at each fast wrap.
  - Fast counter and `blink` are cleared on ADJUST entry.
- **Clear**:
  - Clr press pulses `clr` for one cycle and clears the tick counter.
  - From RUN or PAUSED, next state is PAUSED.
  - In ADJUST, state stays ADJUST and saved mode becomes PAUSED.
- **Simultaneous events**:
  - Clr press beats pause press; the pause press is dropped.
  - Pause presses in ADJUST are ignored.
  - A run tick coinciding with a clr press is suppressed: `clr` only, no `sec_inc`.
- A `sel` change in ADJUST takes effect at the next fast wrap.
- Reset asserted mid-operation overrides everything on that edge, including pending pulses and debounce counters.

## Timing
- All outputs registered, no combinational paths from inputs to outputs.
- A raw button edge that stays stable produces a press pulse exactly DB_CYCLES+3 cycles later: 2 sync + DB_CYCLES + 1 edge register.
- State changes on the edge after the press pulse. `paused` and `adjusting` reflect the new state on that same edge.
- First `sec_inc` comes TICK_DIV cycles after the state becomes RUN with the tick counter at 0. Subsequent pulses are every TICK_DIV cycles.
- First ADJUST increment comes FAST_DIV cycles after ADJUST entry, then every FAST_DIV cycles.
- `clr`, `sec_inc`, `min_inc` are exactly one cycle wide. `clr` is never concurrent with an increment.

## Structure
- Shared package `clock_pkg`:
  - State enum: PAUSED=2'd0, RUN=2'd1, ADJUST=2'd2.
  - BCD rollover constants: SEC_TEN_MAX=5, DIGIT_MAX=9.
- Sub-module `btn_debounce`: synchronizer, stability counter, edge pulse. Parameter DB_CYCLES; ports clk, reset, raw, level, press. Instantiated three times.
- Top holds the FSM, saved-mode register, tick and fast counters, and the `blink` flop. Counter widths are derived with $clog2.

## Test plan
All scenarios use TICK_DIV=10, FAST_DIV=4, DB_CYCLES=3.
- Reset, then one pause press → press at +6 cycles; RUN; `sec_inc` pulses every 10 cycles; `paused`=0.
- RUN with `sec_ten`=5, `sec_one`=9 at a tick → `sec_inc` and `min_inc` high in the same single cycle.
- 2-cycle glitch on `btn_pause` → no press, state unchanged. 5-cycle hold → exactly one press.
- Hold `btn_adj` from RUN with `sel`=0 → `adjusting`=1; `min_inc` every 4 cycles; `blink` toggles every 4 cycles; pause presses ignored. Release → RUN; first `sec_inc` 10 cycles later.
- Clr and pause presses in the same cycle during RUN → single `clr` pulse; state PAUSED; no `sec_inc`.
- Reset asserted mid-ADJUST → next cycle `paused`=1, `adjusting`=0, `blink`=0, no pulses.
